// File: rtl/bist_scan_engine.sv
// ============================================================================
// Module   : bist_scan_engine
// Brief    : LFSR-fed scan-chain self-test of a W x W multiplier with MISR
//            signature compaction and pass/fail against a golden signature.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bist_scan_engine #(
    parameter int              W          = 4,
    parameter logic [2*W-1:0]  SEED       = 8'hBD,
    parameter logic [2*W-1:0]  TAPS       = 8'b1000_1110,
    parameter int              N_PATTERNS = 16,
    parameter logic [2*W-1:0]  GOLDEN     = '0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic                                fault_en,
    output logic                                busy,
    output logic                                done,
    output logic                                pass,
    output logic [2*W-1:0]                      signature,
    output logic                                scan_en,
    output logic                                scan_in,
    output logic                                scan_out,
    output logic [$clog2(N_PATTERNS+1)-1:0]     pattern_cnt
);

    localparam int L  = 2 * W;
    localparam int CW = $clog2(N_PATTERNS + 1);
    localparam int BW = (L > 2) ? $clog2(L) : 1;

    localparam logic [L-1:0]  SEED_EFF = (SEED == '0) ? L'(1) : SEED;
    localparam logic [BW-1:0] BIT_LAST = BW'(L - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N_PATTERNS - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SHIFT   = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_FLUSH   = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [L-1:0]  chain_q, chain_d;
    logic [L-1:0]  lfsr_q,  lfsr_d;
    logic [L-1:0]  sig_q,   sig_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [BW-1:0] bit_q,   bit_d;
    logic          pass_q,  pass_d;

    logic          w_start;
    logic          w_bit_last;
    logic [L-1:0]  w_op_a, w_op_b, w_product;

    assign w_start    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign w_bit_last = (bit_q == BIT_LAST);
    assign w_op_a     = {{W{1'b0}}, chain_q[L-1:W]};
    assign w_op_b     = {{W{1'b0}}, chain_q[W-1:0]};
    assign w_product  = w_op_a * w_op_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start)      state_d = ST_SHIFT;
            ST_SHIFT:         if (w_bit_last) state_d = ST_CAPTURE;
            ST_CAPTURE:       state_d = (cnt_q == CNT_LAST) ? ST_FLUSH : ST_SHIFT;
            ST_FLUSH:         if (w_bit_last) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        scan_en = 1'b0;
        scan_in = lfsr_q[L-1];
        case (state_q)
            ST_SHIFT:   begin busy = 1'b1; scan_en = 1'b1; end
            ST_CAPTURE: busy = 1'b1;
            ST_FLUSH:   begin busy = 1'b1; scan_en = 1'b1; scan_in = 1'b0; end
            ST_DONE:    done = 1'b1;
            default:    ;
        endcase
        pass = done & pass_q;
    end

    assign signature   = sig_q;
    assign scan_out    = chain_q[0];
    assign pattern_cnt = cnt_q;

    always_comb begin
        chain_d = chain_q;
        lfsr_d  = lfsr_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        pass_d  = pass_q;
        if (w_start) begin
            chain_d = '0;
            lfsr_d  = SEED_EFF;
            sig_d   = '0;
            cnt_d   = '0;
            bit_d   = '0;
            pass_d  = 1'b0;
        end else begin
            if (scan_en) begin
                chain_d = {scan_in, chain_q[L-1:1]};
                sig_d   = {sig_q[L-2:0], (^(sig_q & TAPS)) ^ chain_q[0]};
                bit_d   = w_bit_last ? '0 : bit_q + BW'(1);
            end
            if (state_q == ST_SHIFT) begin
                lfsr_d = {lfsr_q[L-2:0], ^(lfsr_q & TAPS)};
            end
            if (state_q == ST_CAPTURE) begin
                chain_d    = w_product;
                chain_d[0] = w_product[0] & ~fault_en;
                cnt_d      = cnt_q + CW'(1);
            end
            // Compare the signature as it will stand once the last flush bit lands.
            if ((state_q == ST_FLUSH) && w_bit_last) begin
                pass_d = (sig_d == GOLDEN);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
            lfsr_q  <= SEED_EFF;
            sig_q   <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            lfsr_q  <= lfsr_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            pass_q  <= pass_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bist_scan_engine.sv
// ============================================================================
// Module   : tb_bist_scan_engine
// Brief    : Scoreboard bench for bist_scan_engine (default and W=3 builds).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bist_scan_engine;

    // Round-level reference: each round shifts in 2W LFSR bits (first bit ends in
    // the chain LSB) while the previous product leaves LSB first into the MISR.
    function automatic logic [31:0] model_sig(input int w, input logic [31:0] seed,
                                              input logic [31:0] taps, input int n,
                                              input logic [31:0] fmask);
        int          l;
        logic [31:0] m, lfsr, sig, chain, pat, a, b;
        l = 2 * w;
        m = (32'd1 << l) - 32'd1;
        lfsr = seed & m;
        if (lfsr == 32'd0) lfsr = 32'd1;
        sig = 32'd0;
        chain = 32'd0;
        for (int r = 0; r < n; r++) begin
            pat = 32'd0;
            for (int k = 0; k < l; k++) begin
                sig = ((sig << 1) | {31'd0, (^(sig & taps)) ^ chain[k]}) & m;
                pat[k] = lfsr[l-1];
                lfsr = ((lfsr << 1) | {31'd0, ^(lfsr & taps)}) & m;
            end
            a = pat >> w;
            b = pat & ((32'd1 << w) - 32'd1);
            chain = a * b;
            if (fmask[r]) chain[0] = 1'b0;
        end
        for (int k = 0; k < l; k++) begin
            sig = ((sig << 1) | {31'd0, (^(sig & taps)) ^ chain[k]}) & m;
        end
        return sig;
    endfunction

    localparam logic [31:0] GOLD1 = model_sig(4, 32'hBD, 32'h8E, 16, 32'd0);
    localparam logic [31:0] GOLD2 = model_sig(3, 32'h2D, 32'h21, 1, 32'd0);
    localparam logic [7:0]  GOLD1_8 = GOLD1[7:0];
    localparam logic [5:0]  GOLD2_6 = GOLD2[5:0];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0, fault1 = 1'b0, start2 = 1'b0, fault2 = 1'b0;
    logic       d1_busy, d1_done, d1_pass, d1_scan_en, d1_scan_in, d1_scan_out;
    logic [7:0] d1_sig;
    logic [4:0] d1_cnt;
    logic       d2_busy, d2_done, d2_pass, d2_scan_en, d2_scan_in, d2_scan_out;
    logic [5:0] d2_sig;
    logic [0:0] d2_cnt;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [31:0] sig;
        logic        pass;
        int          edge_n;
    } exp_t;
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bist_scan_engine u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .fault_en(fault1),
        .busy(d1_busy), .done(d1_done), .pass(d1_pass), .signature(d1_sig),
        .scan_en(d1_scan_en), .scan_in(d1_scan_in), .scan_out(d1_scan_out),
        .pattern_cnt(d1_cnt)
    );

    bist_scan_engine #(
        .W(3), .SEED(6'h2D), .TAPS(6'b100_001), .N_PATTERNS(1), .GOLDEN(GOLD2_6)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .fault_en(fault2),
        .busy(d2_busy), .done(d2_done), .pass(d2_pass), .signature(d2_sig),
        .scan_en(d2_scan_en), .scan_in(d2_scan_in), .scan_out(d2_scan_out),
        .pattern_cnt(d2_cnt)
    );

    // The default instance is rebuilt with its golden value set to the model's.
    defparam u_dut1.GOLDEN = GOLD1_8;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // {busy, done, pass, scan_en, scan_out}
    function automatic logic [31:0] o_flags(input bit inst);
        return inst ? 32'({d2_busy, d2_done, d2_pass, d2_scan_en, d2_scan_out})
                    : 32'({d1_busy, d1_done, d1_pass, d1_scan_en, d1_scan_out});
    endfunction
    function automatic logic [31:0] o_sig(input bit inst);
        return inst ? 32'(d2_sig) : 32'(d1_sig);
    endfunction
    function automatic logic [31:0] o_cnt(input bit inst);
        return inst ? 32'(d2_cnt) : 32'(d1_cnt);
    endfunction
    function automatic logic o_sin(input bit inst);
        return inst ? d2_scan_in : d1_scan_in;
    endfunction

    task automatic drive(input bit inst, input logic s, input logic f);
        if (inst) begin start2 = s; fault2 = f; end
        else      begin start1 = s; fault1 = f; end
    endtask

    task automatic do_run(input bit inst, input logic [31:0] fmask,
                          input int mid_start, input int rst_at);
        int          l, n, total, busy_err, w;
        logic [31:0] seed, taps, gold, exp_sig, prod, exp_in, got_in, got_out, fl;
        exp_t        x;
        bit          cap;
        l     = inst ? 6 : 8;
        w     = l / 2;
        n     = inst ? 1 : 16;
        seed  = inst ? 32'h2D : 32'hBD;
        taps  = inst ? 32'h21 : 32'h8E;
        gold  = inst ? GOLD2 : GOLD1;
        total = n * (l + 1) + l;
        exp_sig = model_sig(w, seed, taps, n, fmask);
        prod = (seed >> w) * (seed & ((32'd1 << w) - 32'd1));
        if (fmask[0]) prod[0] = 1'b0;
        exp_in = 32'd0;
        for (int k = 0; k < l; k++) exp_in[k] = seed[l-1-k];
        if (rst_at < 0) begin
            x.sig    = exp_sig;
            x.pass   = (exp_sig == gold);
            x.edge_n = cyc + 1 + total;
            if (inst) q2.push_back(x); else q1.push_back(x);
        end
        got_in = 32'd0;
        got_out = 32'd0;
        busy_err = 0;
        for (int e = 0; e <= total; e++) begin
            cap = (e > 0) && (e % (l + 1) == 0) && (e <= n * (l + 1));
            drive(inst, (e == 0) || (e == mid_start),
                  cap ? fmask[e / (l + 1) - 1] : 1'($urandom));
            @(posedge clk);
            #1;
            if (e == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_async_flags", o_flags(inst), 32'd0);
                check("rst_async_sig", o_sig(inst), 32'd0);
                check("rst_async_cnt", o_cnt(inst), 32'd0);
                check("rst_async_scan_in", 32'(o_sin(inst)), 32'(seed[l-1]));
                @(posedge clk);
                #1 rst_n = 1'b1;
                break;
            end
            fl = o_flags(inst);
            if (e < total) begin
                if (fl[4] !== 1'b1 || fl[3] !== 1'b0) busy_err++;
            end else begin
                if (fl[4] !== 1'b0 || fl[3] !== 1'b1) busy_err++;
            end
            if (e < l) got_in[e] = o_sin(inst);
            if (e >= l + 1 && e <= 2 * l) got_out[e-l-1] = fl[0];
        end
        drive(inst, 1'b0, 1'b0);
        if (rst_at < 0) begin
            check("scan_in_first_pattern", got_in, exp_in);
            check("first_capture_chain", got_out, prod);
            check("busy_done_profile_errs", 32'(busy_err), 32'd0);
            check("pattern_cnt_final", o_cnt(inst), 32'(n));
        end
    endtask

    task automatic monitor(input bit inst);
        bit   prev;
        exp_t x;
        logic [31:0] fl;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            fl = o_flags(inst);
            if (fl[3] && !prev) begin
                if ((inst ? q2.size() : q1.size()) == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    x = inst ? q2.pop_front() : q1.pop_front();
                    check(inst ? "sig2" : "sig1", o_sig(inst), x.sig);
                    check(inst ? "pass2" : "pass1", 32'(fl[2]), 32'(x.pass));
                    check(inst ? "done_edge2" : "done_edge1", 32'(cyc), 32'(x.edge_n));
                end
            end
            prev = fl[3];
        end
    endtask

    initial monitor(1'b0);
    initial monitor(1'b1);

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_flags1", o_flags(1'b0), 32'd0);
        check("reset_sig1", o_sig(1'b0), 32'd0);
        check("reset_cnt1", o_cnt(1'b0), 32'd0);
        check("reset_scan_in1", 32'(o_sin(1'b0)), 32'd1);
        check("reset_flags2", o_flags(1'b1), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_flags1", o_flags(1'b0), 32'd0);

        do_run(1'b0, 32'd0, -1, -1);                                    // clean run
        do_run(1'b0, 32'd1, -1, -1);                                    // fault on first capture
        do_run(1'b0, 32'd0, 40, -1);                                    // start while busy
        do_run(1'b0, 32'd0, -1, -1);                                    // restart from DONE
        do_run(1'b0, 32'd0, -1, 70);                                    // reset mid-run
        do_run(1'b0, 32'd0, -1, -1);
        repeat (4) begin
            do_run(1'b0, $urandom & 32'hFFFF, int'($urandom_range(1, 151)), -1);
        end
        do_run(1'b1, 32'd0, -1, -1);
        do_run(1'b1, 32'd1, -1, -1);
        do_run(1'b1, 32'd0, int'($urandom_range(1, 12)), -1);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard1_drained", 32'(q1.size()), 32'd0);
        check("scoreboard2_drained", 32'(q2.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
